// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-aligned fetches, tracks in-flight
// requests, buffers returned instructions and handles redirects by
// flushing the buffer and discarding stale responses.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        instr_valid,
    output logic [31:0] instr_memory,
    output logic [31:0] instr_pc
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 2) ? 2 : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   outstanding_q, outstanding_d;
    logic [CNT_W-1:0]   drop_q, drop_d;

    // In-order queue of pcs for live (non-stale) requests
    logic [31:0]        pcq_mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]   pcq_wr_q, pcq_wr_d;
    logic [PTR_W-1:0]   pcq_rd_q, pcq_rd_d;

    // Fetch buffer of {pc, instr}
    logic [31:0]        buf_pc_q    [BUF_DEPTH];
    logic [31:0]        buf_instr_q [BUF_DEPTH];
    logic [PTR_W-1:0]   buf_wr_q, buf_wr_d;
    logic [PTR_W-1:0]   buf_rd_q, buf_rd_d;
    logic [CNT_W-1:0]   buf_count_q, buf_count_d;

    logic               buf_valid;
    logic               pop;
    logic               xfer;
    logic               keep;
    logic               rsp_dec;
    logic [SUM_W-1:0]   slots_used;

    // Handshake and output view; a pop this cycle frees its slot so a
    // 1-cycle memory can sustain one instruction per cycle
    always_comb begin
        buf_valid      = !rst && (buf_count_q != '0);
        instr_valid    = buf_valid;
        instr_memory   = buf_valid ? buf_instr_q[buf_rd_q] : 32'h0;
        instr_pc       = buf_valid ? buf_pc_q[buf_rd_q]    : 32'h0;
        pop            = buf_valid && !stall;
        slots_used     = SUM_W'(outstanding_q) + SUM_W'(buf_count_q) - SUM_W'(pop);
        imem_req_valid = !rst && (state_q != ST_RESET) && !redirect_valid
                         && (slots_used < SUM_W'(BUF_DEPTH));
        imem_addr      = fetch_pc_q;
        xfer           = imem_req_valid && imem_req_ready;
        rsp_dec        = imem_rsp_valid && (outstanding_q != '0);
        keep           = !rst && imem_rsp_valid && !redirect_valid && (drop_q == '0);
    end

    // Next-state: FSM, counters, pc queue and buffer pointers
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CNT_W'(xfer) - CNT_W'(rsp_dec);
        drop_d        = drop_q;
        pcq_wr_d      = pcq_wr_q;
        pcq_rd_d      = pcq_rd_q;
        buf_wr_d      = buf_wr_q;
        buf_rd_d      = buf_rd_q;
        buf_count_d   = buf_count_q;

        if (redirect_valid) begin
            fetch_pc_d  = redirect_pc & 32'hFFFF_FFFC;
            drop_d      = outstanding_q - CNT_W'(rsp_dec);
            pcq_wr_d    = '0;
            pcq_rd_d    = '0;
            buf_wr_d    = '0;
            buf_rd_d    = '0;
            buf_count_d = '0;
        end else begin
            if (imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CNT_W'(1);
            end
            if (xfer) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                pcq_wr_d   = pcq_wr_q + PTR_W'(1);
            end
            if (keep) begin
                pcq_rd_d = pcq_rd_q + PTR_W'(1);
                buf_wr_d = buf_wr_q + PTR_W'(1);
            end
            if (pop) begin
                buf_rd_d = buf_rd_q + PTR_W'(1);
            end
            buf_count_d = buf_count_q + CNT_W'(keep) - CNT_W'(pop);
        end

        case (state_q)
            ST_RESET: state_d = ST_RUN;
            ST_RUN:   if (redirect_valid && (drop_d != '0)) state_d = ST_DRAIN;
            ST_DRAIN: if (drop_d == '0) state_d = ST_RUN;
            default:  state_d = ST_RESET;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RESET;
            fetch_pc_q    <= RESET_PC & 32'hFFFF_FFFC;
            outstanding_q <= '0;
            drop_q        <= '0;
            pcq_wr_q      <= '0;
            pcq_rd_q      <= '0;
            buf_wr_q      <= '0;
            buf_rd_q      <= '0;
            buf_count_q   <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            pcq_wr_q      <= pcq_wr_d;
            pcq_rd_q      <= pcq_rd_d;
            buf_wr_q      <= buf_wr_d;
            buf_rd_q      <= buf_rd_d;
            buf_count_q   <= buf_count_d;
        end
    end

    // Storage arrays; contents are qualified by the pointers and counts
    always_ff @(posedge clk) begin
        if (xfer) begin
            pcq_mem_q[pcq_wr_q] <= fetch_pc_q;
        end
        if (keep) begin
            buf_pc_q[buf_wr_q]    <= pcq_mem_q[pcq_rd_q];
            buf_instr_q[buf_wr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: in-order memory model driving the DUT, a queue-level
// reference model checked every cycle, and directed scenario checks.
module tb_instr_fetch;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        instr_valid;
    logic [31:0] instr_memory;
    logic [31:0] instr_pc;

    instr_fetch #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stall(stall),
        .instr_valid(instr_valid), .instr_memory(instr_memory), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    // Staged inputs, applied on the falling edge
    logic        s_rst = 1'b1, s_ready = 1'b1, s_stall = 1'b0, s_redirect = 1'b0;
    logic [31:0] s_redirect_pc = 32'h0;
    int          lat = 1;
    int          cyc = 0;
    int          checks = 0, failures = 0;

    // Memory model: accepted addresses with due cycle
    logic [31:0] mq_addr[$];
    int          mq_due[$];

    // Reference model
    logic        m_started = 1'b0;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] inf_pc[$];
    bit          inf_stale[$];
    logic [31:0] fq[$];

    // DUT-side logs of transfers and deliveries
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] del_pc[$];
    int          del_cyc[$];

    // Sampled DUT values of the latest step
    logic        d_req, d_iv;
    logic [31:0] d_addr, d_pc;

    // Redirect-on-response trigger
    bit          arm = 1'b0, fired = 1'b0;
    logic [31:0] arm_pc = 32'h0;
    int          fire_del = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [31:0] acc_at(input int i);
        return (i >= 0 && i < acc_addr.size()) ? acc_addr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] del_at(input int i);
        return (i >= 0 && i < del_pc.size()) ? del_pc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic int del_cyc_at(input int i);
        return (i >= 0 && i < del_cyc.size()) ? del_cyc[i] : -1;
    endfunction

    function automatic int acc_cyc_at(input int i);
        return (i >= 0 && i < acc_cyc.size()) ? acc_cyc[i] : -1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s cyc=%0d actual=timeout expected=event", name, cyc);
    endtask

    // One clock cycle: drive, compare against model, then advance model and memory
    task automatic step();
        logic        e_req, e_iv, e_pop, m_xfer, d_xfer, d_pop;
        logic [31:0] e_pc, e_mem, h;
        bit          st;
        @(negedge clk);
        rst            = s_rst;
        imem_req_ready = s_ready;
        stall          = s_stall;
        redirect_valid = s_redirect;
        redirect_pc    = s_redirect_pc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (!rst && mq_addr.size() > 0 && mq_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq_addr[0]);
        end
        if (arm && !rst && imem_rsp_valid && fq.size() > 0 && inf_pc.size() >= 2 && !stall) begin
            redirect_valid = 1'b1;
            redirect_pc    = arm_pc;
            arm            = 1'b0;
            fired          = 1'b1;
            fire_del       = del_pc.size();
        end
        #1;
        e_pop = 1'b0;
        if (rst) begin
            e_req = 1'b0; e_iv = 1'b0; e_pc = 32'h0; e_mem = 32'h0;
        end else begin
            e_iv  = fq.size() > 0;
            e_pc  = e_iv ? fq[0] : 32'h0;
            e_mem = e_iv ? mem_word(fq[0]) : 32'h0;
            e_pop = e_iv && !stall;
            e_req = m_started && !redirect_valid
                    && (inf_pc.size() + fq.size() - int'(e_pop) < DEPTH);
        end
        check("req_valid", 32'(imem_req_valid), 32'(e_req));
        if (e_req) check("req_addr", imem_addr, m_pc);
        check("instr_valid", 32'(instr_valid), 32'(e_iv));
        if (rst || e_iv) begin
            check("instr_pc", instr_pc, e_pc);
            check("instr_memory", instr_memory, e_mem);
        end
        d_req  = imem_req_valid;
        d_iv   = instr_valid;
        d_addr = imem_addr;
        d_pc   = instr_pc;
        m_xfer = e_req && imem_req_ready;
        d_xfer = imem_req_valid && imem_req_ready;
        d_pop  = instr_valid && !stall && !redirect_valid;
        @(posedge clk);
        if (rst) begin
            mq_addr.delete(); mq_due.delete();
            m_started = 1'b0; m_pc = RST_PC;
            inf_pc.delete(); inf_stale.delete(); fq.delete();
        end else begin
            if (d_xfer) begin acc_addr.push_back(d_addr); acc_cyc.push_back(cyc); end
            if (d_pop)  begin del_pc.push_back(d_pc);     del_cyc.push_back(cyc); end
            if (imem_rsp_valid && mq_addr.size() > 0) begin
                void'(mq_addr.pop_front()); void'(mq_due.pop_front());
            end
            if (d_xfer) begin mq_addr.push_back(d_addr); mq_due.push_back(cyc + lat); end
            m_started = 1'b1;
            if (e_pop && !redirect_valid) void'(fq.pop_front());
            if (imem_rsp_valid && inf_pc.size() > 0) begin
                h  = inf_pc.pop_front();
                st = inf_stale.pop_front();
                if (!redirect_valid && !st) fq.push_back(h);
            end
            if (redirect_valid) begin
                fq.delete();
                foreach (inf_stale[i]) inf_stale[i] = 1'b1;
                m_pc = {redirect_pc[31:2], 2'b00};
            end else if (m_xfer) begin
                inf_pc.push_back(m_pc); inf_stale.push_back(1'b0);
                m_pc = m_pc + 32'd4;
            end
        end
        s_redirect = 1'b0;
        cyc++;
    endtask

    initial begin
        int rel, di, ai, n0;
        logic [31:0] last, a0;
        bit ok;

        // Reset, then release with 1-cycle memory: wrap F8, FC, 0 at full rate
        repeat (3) step();
        s_rst = 1'b0;
        rel = cyc;
        repeat (10) step();
        check("first_req_cyc", 32'(acc_cyc_at(0)), 32'(rel + 1));
        check("req0_addr", acc_at(0), 32'hFFFF_FFF8);
        check("req1_addr", acc_at(1), 32'hFFFF_FFFC);
        check("req2_addr", acc_at(2), 32'h0000_0000);
        check("req2_cyc", 32'(acc_cyc_at(2)), 32'(rel + 3));
        check("first_del_cyc", 32'(del_cyc_at(0)), 32'(rel + 3));
        check("del0_pc", del_at(0), 32'hFFFF_FFF8);
        check("del2_pc", del_at(2), 32'h0000_0000);
        check("del_count_10cyc", 32'(del_pc.size()), 32'd7);

        // Stall with buffer filling: output held, requests stop once full
        last = del_pc[del_pc.size() - 1];
        n0   = del_pc.size();
        s_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("stall_iv", 32'(d_iv), 32'd1);
            check("stall_hold_pc", d_pc, last + 32'd4);
            if (i >= 5) check("stall_full_noreq", 32'(d_req), 32'd0);
        end
        s_stall = 1'b0;
        repeat (4) step();
        check("unstall_next", del_at(n0), last + 32'd4);
        check("unstall_after", del_at(n0 + 1), last + 32'd8);
        check("unstall_nogap", 32'(del_cyc_at(n0 + 1) - del_cyc_at(n0)), 32'd1);

        // Memory not ready for 3 cycles: request and address held
        a0 = acc_addr[acc_addr.size() - 1] + 32'd4;
        ai = acc_addr.size();
        s_ready = 1'b0;
        repeat (3) begin
            step();
            check("hold_valid", 32'(d_req), 32'd1);
            check("hold_addr", d_addr, a0);
        end
        s_ready = 1'b1;
        repeat (2) step();
        check("hold_xfer_addr", acc_at(ai), a0);

        // Redirect with two outstanding: misaligned target rounds down
        lat = 3;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            if (inf_pc.size() >= 2) ok = 1'b1; else step();
        end
        if (!ok) fail_now("wait_two_outstanding");
        di = del_pc.size();
        ai = acc_addr.size();
        s_redirect = 1'b1; s_redirect_pc = 32'h0000_0103;
        step();
        repeat (14) step();
        check("redir_req_addr", acc_at(ai), 32'h0000_0100);
        check("redir_first_pc", del_at(di), 32'h0000_0100);
        check("redir_second_pc", del_at(di + 1), 32'h0000_0104);

        // Redirect coinciding with a response and a pop
        lat = 2;
        arm = 1'b1; arm_pc = 32'h0000_0400; fired = 1'b0;
        for (int i = 0; i < 40 && !fired; i++) step();
        if (!fired) fail_now("wait_rsp_pop_redirect");
        repeat (12) step();
        check("rsp_redir_first_pc", del_at(fire_del), 32'h0000_0400);

        // Back-to-back redirects: nothing from the first target escapes
        lat = 3;
        di = del_pc.size();
        ai = acc_addr.size();
        s_redirect = 1'b1; s_redirect_pc = 32'h0000_0200;
        step();
        s_redirect = 1'b1; s_redirect_pc = 32'h0000_0300;
        step();
        repeat (16) step();
        check("b2b_first_req", acc_at(ai), 32'h0000_0300);
        check("b2b_first_pc", del_at(di), 32'h0000_0300);

        // Redirect to 0 with 1-cycle memory: 0, 4, 8 back to back
        lat = 1;
        repeat (4) step();
        di = del_pc.size();
        s_redirect = 1'b1; s_redirect_pc = 32'h0000_0000;
        step();
        repeat (10) step();
        check("zero_pc0", del_at(di), 32'h0000_0000);
        check("zero_pc1", del_at(di + 1), 32'h0000_0004);
        check("zero_pc2", del_at(di + 2), 32'h0000_0008);
        check("zero_rate", 32'(del_cyc_at(di + 2) - del_cyc_at(di)), 32'd2);

        // Reset mid-operation with requests in flight
        lat = 3;
        repeat (3) step();
        s_rst = 1'b1;
        repeat (2) step();
        s_rst = 1'b0;
        ai = acc_addr.size();
        repeat (10) step();
        check("rerst_first_req", acc_at(ai), RST_PC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
